// File: rtl/nibble_window_loader_pkg.sv
// Shared widths, occupancy decode and advance/level arithmetic for the nibble window loader.
// Purely combinational helpers; no state lives here.
package nibble_window_loader_pkg;

  localparam int NIB_W     = 4;
  localparam int WIN_W     = 7;
  localparam int ADV_MAX   = 4;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_READY   = 2'd2,
    OCC_FULL    = 2'd3
  } occ_e;

  // Zero is a legal "no advance"; anything beyond a nibble saturates.
  function automatic logic [2:0] sat_adv(input logic [2:0] adv);
    if (adv > 3'(ADV_MAX)) return 3'(ADV_MAX);
    return adv;
  endfunction

  function automatic logic [4:0] level_calc(input logic [2:0] count, input logic [1:0] offset);
    return {count, 2'b00} - {3'b000, offset};
  endfunction

  function automatic occ_e occ_decode(input logic [2:0] count, input logic [2:0] depth);
    if (count == 3'd0) return OCC_EMPTY;
    if (count == 3'd1) return OCC_PARTIAL;
    if (count == depth) return OCC_FULL;
    return OCC_READY;
  endfunction

endpackage

// File: rtl/nibble_window_loader_buf.sv
// DEPTH-slot nibble shift buffer, oldest in slot 0; push/pop/flush take effect next cycle.
// No internal backpressure: the caller only pushes when not full and pops when at least two slots are held.
module nibble_window_loader_buf
  import nibble_window_loader_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [NIB_W-1:0] data_i,
  output logic [2:0]       count_o,
  output logic [WIN_W-1:0] win_o
);

  logic [NIB_W-1:0] nib_q [DEPTH];
  logic [NIB_W-1:0] nib_d [DEPTH];
  logic [2:0]       count_q, count_d;
  logic [2:0]       wr_idx;
  logic [NIB_W-1:0] win_lo;
  logic [2:0]       win_hi;

  // With a simultaneous pop everything slides down one, so the new nibble lands one slot lower.
  assign wr_idx = pop_i ? (count_q - 3'd1) : count_q;

  always_comb begin
    nib_d   = nib_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) nib_d[i] = '0;
      count_d = 3'd0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH - 1; i++) nib_d[i] = nib_q[i+1];
        nib_d[DEPTH-1] = '0;
      end
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (3'(i) == wr_idx) nib_d[i] = data_i;
        end
      end
      count_d = count_q + {2'b00, push_i} - {2'b00, pop_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) nib_q[i] <= '0;
      count_q <= 3'd0;
    end else begin
      nib_q   <= nib_d;
      count_q <= count_d;
    end
  end

  // Unoccupied slots read as zero regardless of what the register holds.
  assign win_lo  = (count_q >= 3'd1) ? nib_q[0] : '0;
  assign win_hi  = (count_q >= 3'd2) ? nib_q[1][2:0] : '0;
  assign win_o   = {win_hi, win_lo};
  assign count_o = count_q;

endmodule

// File: rtl/nibble_window_loader.sv
// Feeds a 4-bit barrel shifter a 7-bit window plus bit offset; pushes and advances show up one cycle later.
// in_ready drops only when the buffer is full and never looks at out_ready; out_valid needs two nibbles held.
module nibble_window_loader
  import nibble_window_loader_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NIB_W-1:0] in_data_i,
  output logic [WIN_W-1:0] win_o,
  output logic             s1_o,
  output logic             s0_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic [2:0]       adv_i,
  output logic [4:0]       level_o
);

  localparam int DEPTH_C = (DEPTH < DEPTH_MIN) ? DEPTH_MIN :
                           (DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH;
  localparam logic [2:0] DEPTH_L = 3'(DEPTH_C);

  logic [1:0] offset_q, offset_d;
  logic [2:0] count;
  logic [2:0] sum;
  logic       push, pop, consume;
  occ_e       occ;

  assign occ         = occ_decode(count, DEPTH_L);
  assign out_valid_o = (occ == OCC_READY) || (occ == OCC_FULL);
  assign in_ready_o  = (occ != OCC_FULL);

  assign push    = in_valid_i && in_ready_o;
  assign consume = out_valid_o && out_ready_i;
  assign sum     = {1'b0, offset_q} + sat_adv(adv_i);
  // Crossing a nibble boundary retires nib[0]; the remainder in sum[1:0] is the new offset either way.
  assign pop     = consume && sum[2];

  always_comb begin
    offset_d = offset_q;
    if (flush_i)      offset_d = 2'd0;
    else if (consume) offset_d = sum[1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) offset_q <= 2'd0;
    else          offset_q <= offset_d;
  end

  nibble_window_loader_buf #(
    .DEPTH (DEPTH_C)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (in_data_i),
    .count_o (count),
    .win_o   (win_o)
  );

  assign s1_o    = offset_q[1];
  assign s0_o    = offset_q[0];
  assign level_o = level_calc(count, offset_q);

endmodule
